// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Single-stage conditional branch resolver sitting between decode and the
// branch-select mux. One branch is accepted per cycle. The operand compare and
// the PC+Imm add happen in the accept cycle, and the results are registered.
// The resolved branch is offered downstream one cycle later.
//
// The same unit also does three other jobs:
//   - compares the resolved direction with the prediction made at fetch time
//     and flags a mispredict;
//   - trains a small 2-bit bimodal branch history table (BHT), which fetch
//     reads combinationally;
//   - keeps saturating statistics counters for the performance registers.
//
// Training and statistics happen when the result is consumed
// (res_valid & res_ready), not when the branch is accepted. This means a
// branch that gets flushed out of the stage never leaves a trace.
//
// Parameters
//   BHT_IDX_W  BHT index width; 2**BHT_IDX_W entries indexed by pc[BHT_IDX_W+1:2]
//   CNT_W      width of each statistics counter
//
// Ports
//   i_clk, i_rst               clock, asynchronous active-high reset
//   i_flush                    kill the in-flight stage and any same-cycle accept
//   i_br_valid / o_br_ready    decode handshake
//   i_br_op                    0 BEQ,1 BNE,4 BLT,5 BGE,6 BLTU,7 BGEU (2,3 illegal)
//   i_br_pc, i_br_imm          branch PC and sign-extended byte offset
//   i_br_rs1, i_br_rs2         compare operands
//   i_br_pred_taken            direction predicted at fetch
//   i_fetch_pc / o_fetch_pred  combinational BHT lookup for fetch
//   o_res_valid / i_res_ready  result handshake
//   o_res_taken                branch mux select (1 = PC+Imm)
//   o_res_target               br_pc + br_imm
//   o_res_fallthru             br_pc + 4
//   o_res_mispredict           taken differs from the fetch prediction
//   o_res_illegal              op was 2 or 3; taken forced to 0
//   o_cnt_branches/_taken/_mispred  saturating statistics counters
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,

    input  logic              i_br_valid,
    output logic              o_br_ready,
    input  logic [2:0]        i_br_op,
    input  logic [31:0]       i_br_pc,
    input  logic [31:0]       i_br_imm,
    input  logic [31:0]       i_br_rs1,
    input  logic [31:0]       i_br_rs2,
    input  logic              i_br_pred_taken,

    input  logic [31:0]       i_fetch_pc,
    output logic              o_fetch_pred,

    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_res_taken,
    output logic [31:0]       o_res_target,
    output logic [31:0]       o_res_fallthru,
    output logic              o_res_mispredict,
    output logic              o_res_illegal,

    output logic [CNT_W-1:0]  o_cnt_branches,
    output logic [CNT_W-1:0]  o_cnt_taken,
    output logic [CNT_W-1:0]  o_cnt_mispred
);

    localparam int BHT_N = 1 << BHT_IDX_W;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLT  = 3'd4,
        OP_BGE  = 3'd5,
        OP_BLTU = 3'd6,
        OP_BGEU = 3'd7
    } br_op_e;

    // Pipeline stage registers
    logic                 r_res_valid;
    logic                 r_res_taken;
    logic [31:0]          r_res_target;
    logic [31:0]          r_res_fallthru;
    logic                 r_res_mispredict;
    logic                 r_res_illegal;
    logic [BHT_IDX_W-1:0] r_bht_idx;

    // Branch history table and statistics
    logic [1:0]           r_bht [BHT_N];
    logic [CNT_W-1:0]     r_cnt_branches;
    logic [CNT_W-1:0]     r_cnt_taken;
    logic [CNT_W-1:0]     r_cnt_mispred;

    // Combinational helpers
    logic                 w_accept;
    logic                 w_commit;
    logic                 w_eq;
    logic                 w_lt_s;
    logic                 w_lt_u;
    logic                 w_taken;
    logic                 w_illegal;
    logic [BHT_IDX_W-1:0] w_br_idx;
    logic [BHT_IDX_W-1:0] w_fetch_idx;
    logic [1:0]           w_bht_cur;
    logic [1:0]           w_bht_next;
    logic                 w_unused_fetch_bits;

    // Single stage that can refill in the same cycle it drains, so full
    // throughput needs no bubble.
    assign o_br_ready = ~r_res_valid | i_res_ready;
    assign w_accept   = i_br_valid & o_br_ready;

    // A result consumed in the same cycle as a flush belongs to the killed
    // path. It must not train the BHT or bump the counters.
    assign w_commit   = r_res_valid & i_res_ready & ~i_flush;

    assign w_br_idx    = i_br_pc[BHT_IDX_W+1:2];
    assign w_fetch_idx = i_fetch_pc[BHT_IDX_W+1:2];

    // Only the index bits of the fetch address matter to the table.
    assign w_unused_fetch_bits = ^{i_fetch_pc[31:BHT_IDX_W+2], i_fetch_pc[1:0]};

    // The BHT is read before the clock edge. A same-cycle write to the entry
    // is therefore not visible until the next cycle.
    assign o_fetch_pred = r_bht[w_fetch_idx][1];

    // Branch condition evaluation. Ops 2 and 3 are illegal; they are flagged
    // and forced not-taken so the mux keeps the fall-through path.
    always_comb begin
        w_eq      = (i_br_rs1 == i_br_rs2);
        w_lt_s    = ($signed(i_br_rs1) < $signed(i_br_rs2));
        w_lt_u    = (i_br_rs1 < i_br_rs2);
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (i_br_op)
            OP_BEQ:  w_taken = w_eq;
            OP_BNE:  w_taken = ~w_eq;
            OP_BLT:  w_taken = w_lt_s;
            OP_BGE:  w_taken = ~w_lt_s;
            OP_BLTU: w_taken = w_lt_u;
            OP_BGEU: w_taken = ~w_lt_u;
            default: w_illegal = 1'b1;
        endcase
    end

    // Saturating 2-bit counter step for the entry of the branch being
    // committed. The entry moves toward 3 on taken and toward 0 otherwise.
    always_comb begin
        w_bht_cur  = r_bht[r_bht_idx];
        w_bht_next = w_bht_cur;
        if (r_res_taken) begin
            if (w_bht_cur != 2'b11) begin
                w_bht_next = w_bht_cur + 2'd1;
            end
        end else begin
            if (w_bht_cur != 2'b00) begin
                w_bht_next = w_bht_cur - 2'd1;
            end
        end
    end

    // Valid bit of the stage. A flush takes priority over everything and
    // also drops any branch accepted in the same cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
        end else if (i_flush) begin
            r_res_valid <= 1'b0;
        end else if (w_accept) begin
            r_res_valid <= 1'b1;
        end else if (i_res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Result payload. It loads only on a real accept. While the stage is
    // stalled, br_ready is low, so the payload holds stable.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_taken      <= 1'b0;
            r_res_target     <= 32'd0;
            r_res_fallthru   <= 32'd0;
            r_res_mispredict <= 1'b0;
            r_res_illegal    <= 1'b0;
            r_bht_idx        <= '0;
        end else if (w_accept && !i_flush) begin
            r_res_taken      <= w_taken;
            r_res_target     <= i_br_pc + i_br_imm;
            r_res_fallthru   <= i_br_pc + 32'd4;
            r_res_mispredict <= w_taken ^ i_br_pred_taken;
            r_res_illegal    <= w_illegal;
            r_bht_idx        <= w_br_idx;
        end
    end

    // BHT training at commit. Every entry starts weakly not-taken (01).
    // Illegal ops carry no real direction, so they never train the table.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_commit && !r_res_illegal) begin
            r_bht[r_bht_idx] <= w_bht_next;
        end
    end

    // Statistics counters. They stick at all-ones instead of wrapping.
    // Illegal ops show up in the branch count only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt_branches <= '0;
            r_cnt_taken    <= '0;
            r_cnt_mispred  <= '0;
        end else if (w_commit) begin
            if (r_cnt_branches != '1) begin
                r_cnt_branches <= r_cnt_branches + CNT_W'(1);
            end
            if (r_res_taken && !r_res_illegal && r_cnt_taken != '1) begin
                r_cnt_taken <= r_cnt_taken + CNT_W'(1);
            end
            if (r_res_mispredict && !r_res_illegal && r_cnt_mispred != '1) begin
                r_cnt_mispred <= r_cnt_mispred + CNT_W'(1);
            end
        end
    end

    assign o_res_valid      = r_res_valid;
    assign o_res_taken      = r_res_taken;
    assign o_res_target     = r_res_target;
    assign o_res_fallthru   = r_res_fallthru;
    assign o_res_mispredict = r_res_mispredict;
    assign o_res_illegal    = r_res_illegal;
    assign o_cnt_branches   = r_cnt_branches;
    assign o_cnt_taken      = r_cnt_taken;
    assign o_cnt_mispred    = r_cnt_mispred;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Bench for branch_resolve_unit. Two instances share every input:
//   - the main one, with 16-bit counters;
//   - a second one, with 2-bit counters, so counter saturation is reachable.
//
// Expected values come from a behavioural model of the branch stage. The
// model holds:
//   - one pending-result record;
//   - an integer array standing in for the BHT;
//   - plain integer counters clipped at their maximum.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        brValid;
    logic        brReady;
    logic [2:0]  brOp;
    logic [31:0] brPc, brImm, brRs1, brRs2;
    logic        brPred;
    logic [31:0] fetchPc;
    logic        fetchPred;
    logic        resValid, resReady, resTaken, resMisp, resIll;
    logic [31:0] resTarget, resFall;
    logic [15:0] cntBr, cntTk, cntMp;

    logic        sBrReady, sFetchPred, sResValid, sResTaken, sResMisp, sResIll;
    logic [31:0] sResTarget, sResFall;
    logic [1:0]  sCntBr, sCntTk, sCntMp;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          mValid;
    bit          mTaken, mMisp, mIll;
    logic [31:0] mTarget, mFall, mPc;
    int          mBht [16];
    int          mCntB, mCntT, mCntM;
    int          mSmB, mSmT, mSmM;

    always #5 clk = ~clk;

    branch_resolve_unit #(.BHT_IDX_W(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_br_valid(brValid), .o_br_ready(brReady), .i_br_op(brOp),
        .i_br_pc(brPc), .i_br_imm(brImm), .i_br_rs1(brRs1), .i_br_rs2(brRs2),
        .i_br_pred_taken(brPred), .i_fetch_pc(fetchPc), .o_fetch_pred(fetchPred),
        .o_res_valid(resValid), .i_res_ready(resReady), .o_res_taken(resTaken),
        .o_res_target(resTarget), .o_res_fallthru(resFall),
        .o_res_mispredict(resMisp), .o_res_illegal(resIll),
        .o_cnt_branches(cntBr), .o_cnt_taken(cntTk), .o_cnt_mispred(cntMp)
    );

    branch_resolve_unit #(.BHT_IDX_W(4), .CNT_W(2)) dutSmall (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_br_valid(brValid), .o_br_ready(sBrReady), .i_br_op(brOp),
        .i_br_pc(brPc), .i_br_imm(brImm), .i_br_rs1(brRs1), .i_br_rs2(brRs2),
        .i_br_pred_taken(brPred), .i_fetch_pc(fetchPc), .o_fetch_pred(sFetchPred),
        .o_res_valid(sResValid), .i_res_ready(resReady), .o_res_taken(sResTaken),
        .o_res_target(sResTarget), .o_res_fallthru(sResFall),
        .o_res_mispredict(sResMisp), .o_res_illegal(sResIll),
        .o_cnt_branches(sCntBr), .o_cnt_taken(sCntTk), .o_cnt_mispred(sCntMp)
    );

    // Single comparison point. It counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Branch direction straight from the ISA definition.
    function automatic bit refTaken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Compare all registered outputs and counters against the model.
    task automatic checkState(input string where);
        checkOutput({where, ".valid"}, resValid, mValid);
        checkOutput({where, ".s_valid"}, sResValid, mValid);
        if (mValid) begin
            checkOutput({where, ".taken"}, resTaken, mTaken);
            checkOutput({where, ".target"}, resTarget, mTarget);
            checkOutput({where, ".fallthru"}, resFall, mFall);
            checkOutput({where, ".mispredict"}, resMisp, mMisp);
            checkOutput({where, ".illegal"}, resIll, mIll);
        end
        checkOutput({where, ".cnt_branches"}, cntBr, mCntB);
        checkOutput({where, ".cnt_taken"}, cntTk, mCntT);
        checkOutput({where, ".cnt_mispred"}, cntMp, mCntM);
        checkOutput({where, ".s_cnt_branches"}, sCntBr, mSmB);
        checkOutput({where, ".s_cnt_taken"}, sCntTk, mSmT);
        checkOutput({where, ".s_cnt_mispred"}, sCntMp, mSmM);
    endtask

    // Drive one cycle of inputs and check the combinational outputs before
    // the edge. Then advance the model and check registered outputs after it.
    task automatic applyStimulus(input bit fl, input bit v, input logic [2:0] op,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input bit pred, input bit rr, input logic [31:0] fpc);
        bit accept, commit;
        int idx;
        flush = fl; brValid = v; brOp = op; brPc = pc; brImm = imm;
        brRs1 = a; brRs2 = b; brPred = pred; resReady = rr; fetchPc = fpc;
        #1;
        checkOutput("br_ready", brReady, !mValid || rr);
        checkOutput("fetch_pred", fetchPred, mBht[(fpc >> 2) % 16] >= 2);
        accept = v && (!mValid || rr);
        commit = mValid && rr && !fl;
        @(posedge clk);
        if (commit) begin
            if (mCntB < 65535) mCntB++;
            if (mSmB < 3) mSmB++;
            if (!mIll) begin
                idx = (mPc >> 2) % 16;
                if (mTaken) mBht[idx] = (mBht[idx] < 3) ? mBht[idx] + 1 : 3;
                else        mBht[idx] = (mBht[idx] > 0) ? mBht[idx] - 1 : 0;
                if (mTaken) begin
                    if (mCntT < 65535) mCntT++;
                    if (mSmT < 3) mSmT++;
                end
                if (mMisp) begin
                    if (mCntM < 65535) mCntM++;
                    if (mSmM < 3) mSmM++;
                end
            end
        end
        if (fl) begin
            mValid = 0;
        end else if (accept) begin
            mValid  = 1;
            mIll    = (op == 3'd2) || (op == 3'd3);
            mTaken  = refTaken(op, a, b);
            mMisp   = mTaken != pred;
            mTarget = pc + imm;
            mFall   = pc + 32'd4;
            mPc     = pc;
        end else if (rr) begin
            mValid = 0;
        end
        #1;
        checkState("cyc");
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic doReset();
        rst = 1'b1;
        flush = 0; brValid = 0; brOp = 0; brPc = 0; brImm = 0; brRs1 = 0;
        brRs2 = 0; brPred = 0; resReady = 0; fetchPc = 0;
        mValid = 0; mCntB = 0; mCntT = 0; mCntM = 0; mSmB = 0; mSmT = 0; mSmM = 0;
        for (int i = 0; i < 16; i++) mBht[i] = 1;
        #1;
        checkOutput("rst.taken", resTaken, 0);
        checkOutput("rst.mispredict", resMisp, 0);
        checkOutput("rst.illegal", resIll, 0);
        checkOutput("rst.target", resTarget, 0);
        checkOutput("rst.fallthru", resFall, 0);
        checkOutput("rst.fetch_pred", fetchPred, 0);
        checkState("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [31:0] opnds [6];
    logic [31:0] pcChoice;

    initial begin
        opnds[0] = 32'd0; opnds[1] = 32'd1; opnds[2] = 32'd5;
        opnds[3] = 32'hFFFF_FFFF; opnds[4] = 32'h8000_0000; opnds[5] = 32'h7FFF_FFFF;
        rst = 1'b1;
        #2;
        doReset();

        // BEQ example, then two more taken commits to the same pc
        applyStimulus(0, 1, 3'd0, 32'h100, 32'h20, 5, 5, 0, 1, 32'h100);
        checkOutput("beq.taken", resTaken, 1);
        checkOutput("beq.target", resTarget, 32'h120);
        checkOutput("beq.fallthru", resFall, 32'h104);
        checkOutput("beq.mispredict", resMisp, 1);
        applyStimulus(0, 1, 3'd0, 32'h100, 32'h20, 5, 5, 0, 1, 32'h100);
        applyStimulus(0, 1, 3'd0, 32'h100, 32'h20, 5, 5, 0, 1, 32'h100);
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h100);
        checkOutput("bht.trained", fetchPred, 1);
        checkOutput("cnt_taken.3", cntTk, 3);

        // Signed vs unsigned compare on the same operands
        doReset();
        applyStimulus(0, 1, 3'd4, 32'h200, 32'h8, 32'hFFFF_FFFF, 1, 0, 1, 32'h0);
        checkOutput("blt.taken", resTaken, 1);
        applyStimulus(0, 1, 3'd6, 32'h200, 32'h8, 32'hFFFF_FFFF, 1, 0, 1, 32'h0);
        checkOutput("bltu.taken", resTaken, 0);

        // Backpressure: three stalled cycles, then exactly one commit
        doReset();
        applyStimulus(0, 1, 3'd1, 32'h300, 32'h40, 1, 2, 1, 0, 32'h300);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 3'd0, 32'h400, 32'h10, 7, 7, 0, 0, 32'h300);
            checkOutput("stall.br_ready", brReady, 0);
            checkOutput("stall.target", resTarget, 32'h340);
        end
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h300);
        checkOutput("stall.one_commit", cntBr, 1);

        // Five mispredicting commits saturate the narrow counter
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 3'd1, 32'h500, 32'h4, 9, 9, 1, 1, 32'h500);
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h500);
        checkOutput("mispred.sat", sCntMp, 3);
        checkOutput("mispred.wide", cntMp, 5);

        // Flush with a pending result and a new accept in the same cycle
        doReset();
        applyStimulus(0, 1, 3'd0, 32'h600, 32'h4, 3, 3, 0, 0, 32'h600);
        applyStimulus(1, 1, 3'd0, 32'h600, 32'h4, 3, 3, 0, 1, 32'h600);
        checkOutput("flush.valid", resValid, 0);
        checkOutput("flush.cnt", cntBr, 0);
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0, 0, 0, 0, 1, 32'h600);
        checkOutput("flush.bht", fetchPred, 0);

        // Address wraparound
        applyStimulus(0, 1, 3'd5, 32'hFFFF_FFFC, 32'h8, 4, 4, 1, 1, 32'h0);
        checkOutput("wrap.fallthru", resFall, 32'h0);
        checkOutput("wrap.target", resTarget, 32'h4);

        // Reset in the middle of a stalled result, then randomized traffic
        applyStimulus(0, 1, 3'd0, 32'h700, 32'h4, 1, 1, 0, 0, 32'h700);
        doReset();
        for (int n = 0; n < 400; n++) begin
            pcChoice = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : ($urandom_range(0, 31) << 2);
            applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                          3'($urandom_range(0, 7)), pcChoice, 32'($urandom_range(0, 255)) - 32'd128,
                          opnds[$urandom_range(0, 5)], opnds[$urandom_range(0, 5)],
                          $urandom_range(0, 1), $urandom_range(0, 3) != 0,
                          32'($urandom_range(0, 31)) << 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
